// File: rtl/pipelined_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_adder                                              |
// | Description : Slice-pipelined adder/subtractor with ARM-style NZCV flags   |
// |               and valid/ready streaming on both sides.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int W_S = WIDTH / STAGES;

  logic w_stall;
  logic w_en;
  logic r_v;

  // Global stall: a held result freezes every stage, bubbles included.
  assign w_stall  = out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = ~w_stall;

  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stage
      // LO: first bit added here; IW: operand bits still pending on entry;
      // SW: result bits complete once this stage has registered.
      localparam int LO = i * W_S;
      localparam int IW = WIDTH - LO;
      localparam int SW = LO + W_S;

      logic [IW-1:0]  w_opa;
      logic [IW-1:0]  w_opb;
      logic           w_vin;
      logic           w_cin;
      logic           w_zin;
      logic [W_S:0]   w_add;
      logic [SW-1:0]  w_sum_nxt;
      logic           r_valid;
      logic           r_carry;
      logic           r_zero;
      logic [SW-1:0]  r_sum;

      if (i == 0) begin : g_head
        // Operand B is conditionally inverted once, at the entry point.
        assign w_opa     = a;
        assign w_opb     = sub ? ~b : b;
        assign w_vin     = in_valid;
        assign w_cin     = cin;
        assign w_zin     = 1'b1;
        assign w_sum_nxt = w_add[W_S-1:0];
      end else begin : g_body
        assign w_opa     = g_stage[i-1].g_skew.r_opa;
        assign w_opb     = g_stage[i-1].g_skew.r_opb;
        assign w_vin     = g_stage[i-1].r_valid;
        assign w_cin     = g_stage[i-1].r_carry;
        assign w_zin     = g_stage[i-1].r_zero;
        assign w_sum_nxt = {w_add[W_S-1:0], g_stage[i-1].r_sum};
      end

      assign w_add = {1'b0, w_opa[W_S-1:0]} + {1'b0, w_opb[W_S-1:0]}
                   + {{W_S{1'b0}}, w_cin};

      // Slice result, carry, running zero bit and valid advance together.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_valid <= 1'b0;
          r_carry <= 1'b0;
          r_zero  <= 1'b0;
          r_sum   <= '0;
        end else if (w_en) begin
          r_valid <= w_vin;
          r_carry <= w_add[W_S];
          r_zero  <= w_zin & (w_add[W_S-1:0] == '0);
          r_sum   <= w_sum_nxt;
        end
      end

      if (IW > W_S) begin : g_skew
        logic [IW-W_S-1:0] r_opa;
        logic [IW-W_S-1:0] r_opb;

        // Upper operand slices wait here until their stage comes up.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_opa <= '0;
            r_opb <= '0;
          end else if (w_en) begin
            r_opa <= w_opa[IW-1:W_S];
            r_opb <= w_opb[IW-1:W_S];
          end
        end
      end

      if (i == STAGES - 1) begin : g_tail
        // Overflow: carry into the MSB (recovered from the MSB sum bit) XOR carry out.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_v <= 1'b0;
          end else if (w_en) begin
            r_v <= (w_opa[W_S-1] ^ w_opb[W_S-1] ^ w_add[W_S-1]) ^ w_add[W_S];
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign n         = sum[WIDTH-1];
  assign z         = g_stage[STAGES-1].r_zero;
  assign c         = g_stage[STAGES-1].r_carry;
  assign v         = r_v;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipelined_adder                                           |
// | Description : Directed self-checking bench for pipelined_adder             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Default 32/4 instance
  logic        in_valid, in_ready, out_valid, out_ready, cin, sub, n, z, c, v;
  logic [31:0] a, b, sum;

  // Shared 8-bit operands for the corner instances
  logic [7:0] a8, b8;
  logic       cin8, sub8, s_out_ready;
  logic       s1_in_valid, s1_in_ready, s1_out_valid, s1_n, s1_z, s1_c, s1_v;
  logic [7:0] s1_sum;
  logic       s8_in_valid, s8_in_ready, s8_out_valid, s8_n, s8_z, s8_c, s8_v;
  logic [7:0] s8_sum;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .n(n), .z(z), .c(c), .v(v)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .reset_n(reset_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(s1_out_valid),
    .out_ready(s_out_ready), .sum(s1_sum), .n(s1_n), .z(s1_z), .c(s1_c), .v(s1_v)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .reset_n(reset_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(s8_out_valid),
    .out_ready(s_out_ready), .sum(s8_sum), .n(s8_n), .z(s8_z), .c(s8_c), .v(s8_v)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // One transaction on the 32/4 instance; latency counted from the accept edge.
  task automatic run_vec(input vec_t tv, input string tag);
    int lat;
    @(negedge clk);
    a = tv.a; b = tv.b; cin = tv.cin; sub = tv.sub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 32'd4);
    chk({tag, " sum"}, sum, tv.sum);
    chk1({tag, " n"}, n, tv.n);
    chk1({tag, " z"}, z, tv.z);
    chk1({tag, " c"}, c, tv.c);
    chk1({tag, " v"}, v, tv.v);
  endtask

  // One transaction on an 8-bit corner instance (deep=1 selects STAGES=8).
  task automatic run8(input bit deep, input logic [7:0] ta, input logic [7:0] tbv,
                      input logic tcin, input logic tsub, input logic [7:0] esum,
                      input logic en, input logic ez, input logic ec, input logic ev,
                      input int elat, input string tag);
    int   lat;
    logic ov;
    @(negedge clk);
    a8 = ta; b8 = tbv; cin8 = tcin; sub8 = tsub;
    if (deep) s8_in_valid = 1'b1; else s1_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s1_in_valid = 1'b0; s8_in_valid = 1'b0;
    lat = 1;
    ov = deep ? s8_out_valid : s1_out_valid;
    while (!ov && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      ov = deep ? s8_out_valid : s1_out_valid;
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " sum"}, {24'd0, (deep ? s8_sum : s1_sum)}, {24'd0, esum});
    chk1({tag, " n"}, deep ? s8_n : s1_n, en);
    chk1({tag, " z"}, deep ? s8_z : s1_z, ez);
    chk1({tag, " c"}, deep ? s8_c : s1_c, ec);
    chk1({tag, " v"}, deep ? s8_v : s1_v, ev);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int sent, recv, stall_left, last_drain, stall_seen, extra;
  bit started;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; s_out_ready = 1'b1;
    s1_in_valid = 1'b0; s8_in_valid = 1'b0;

    //            a             b             cin   sub   sum           n     z     c     v
    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{32'h00000003, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h00000010, 32'h00000003, 1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state, held across clock edges
    repeat (2) @(posedge clk);
    #1;
    chk1("reset out_valid", out_valid, 1'b0);
    chk1("reset in_ready", in_ready, 1'b1);
    chk("reset sum", sum, 32'h0);
    chk1("reset n", n, 1'b0);
    chk1("reset z", z, 1'b0);
    chk1("reset c", c, 1'b0);
    chk1("reset v", v, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven single transactions
    for (int k = 0; k < 11; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Back-pressure: 8 back-to-back, 3-cycle stall at the first result
    repeat (3) @(negedge clk);
    sent = 0; recv = 0; stall_left = 0; last_drain = -1; stall_seen = 0; started = 1'b0;
    for (int t = 0; t < 40 && recv < 8; t++) begin
      @(negedge clk);
      if (out_valid && !started) begin
        started = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      in_valid = (sent < 8);
      a = 32'(sent + 1); b = 32'(sent + 1); cin = 1'b0; sub = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        stall_seen++;
        chk1("stall in_ready", in_ready, 1'b0);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream sum %0d", recv), sum, 32'(2 * (recv + 1)));
        recv++;
        last_drain = t;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream count", recv, 32'd8);
    chk("stall cycles", stall_seen, 32'd3);
    chk("last drain cycle", last_drain, 32'd14);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream duplicates", extra, 32'd0);

    // Reset mid-operation with three transactions in flight
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
      a = (t == 0) ? 32'h7FFFFFFF : 32'h11111111;
      b = (t == 0) ? 32'h00000001 : 32'h22222222;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk1("pre-reset out_valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("async reset out_valid", out_valid, 1'b0);
    chk("async reset sum", sum, 32'h0);
    chk1("async reset n", n, 1'b0);
    chk1("async reset v", v, 1'b0);
    chk1("async reset in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stale after reset", extra, 32'h0);
    run_vec(vecs[3], "post-reset");

    // Parameter corners
    run8(1'b0, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1, "s1 sub");
    run8(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1, "s1 wrap");
    run8(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8, "s8 wrap");
    run8(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 8, "s8 ovf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
